fir_filter: RTL and testbench

- Direct-form FIR filter; the datapath core of the signal-processing top level.
- Takes one signed sample per enabled clock and a parallel bank of signed coefficients.
- Produces a registered full-precision signed sum of products.
- Coefficients are software-loaded upstream (AXI register bank) and presented as a static array.

---
 rtl/fir_filter_pkg.sv | 20 ++
 rtl/fir_filter_if.sv | 29 ++
 rtl/fir_filter_mac.sv | 18 +
 rtl/fir_filter.sv | 58 +++++
 tb/tb_fir_filter.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/fir_filter_pkg.sv
// Shared constants and types for the FIR filter slice.
//   DATA_WIDTH      sample / coefficient width (signed two's complement)
//   NOF_COEFF       number of taps
//   ACC_DATA_WIDTH  output width, wide enough that the tap sum never overflows
//   RST_*           reset timing used by benches driving this block
package fir_filter_pkg;

   localparam int unsigned DATA_WIDTH     = 16;
   localparam int unsigned NOF_COEFF      = 8;
   localparam int unsigned ACC_DATA_WIDTH = 2 * DATA_WIDTH + $clog2(NOF_COEFF);

   typedef logic signed [DATA_WIDTH-1:0]     sample_t;
   typedef logic signed [ACC_DATA_WIDTH-1:0] acc_t;
   typedef sample_t                          coeff_arr_t [NOF_COEFF];

   // Reset timing: initial delay in time units, hold length in clock cycles.
   localparam int unsigned RST_INITIAL_DELAY = 3;
   localparam int unsigned RST_HOLD_DELAY    = 3;

endpackage

// File: rtl/fir_filter_if.sv
// Data-path bundle of the FIR filter.
//   enable        sample-valid strobe
//   input_sample  newest sample x[n]
//   coeff         static tap weights, coeff[0] multiplies the newest sample
//   fir_output    registered filter output y[n]
// master drives samples/coefficients, slave is the filter.
interface fir_filter_if;
   import fir_filter_pkg::*;

   logic       enable;
   sample_t    input_sample;
   coeff_arr_t coeff;
   acc_t       fir_output;

   modport master (
      output enable,
      output input_sample,
      output coeff,
      input  fir_output
   );

   modport slave (
      input  enable,
      input  input_sample,
      input  coeff,
      output fir_output
   );

endinterface

// File: rtl/fir_filter_mac.sv
// One FIR tap: full-precision signed multiply, sign-extended to the accumulator width.
//   sample   delay-line entry
//   weight   tap coefficient
//   product  sample * weight as acc_t
module fir_filter_mac
   import fir_filter_pkg::*;
(
   input  sample_t sample,
   input  sample_t weight,
   output acc_t    product
);

   logic signed [2*DATA_WIDTH-1:0] full;

   assign full    = sample * weight;
   assign product = acc_t'(full);

endmodule

// File: rtl/fir_filter.sv
// Direct-form FIR filter with a one-cycle registered output.
//   clk    rising-edge clock
//   rst_n  synchronous reset, asserted HIGH (legacy name)
//   bus    slave side of fir_filter_if (enable, input_sample, coeff, fir_output)
// On an enabled edge the delay line shifts in the new sample and the output register
// captures the sum of products over the shifted line in the same edge.
module fir_filter
   import fir_filter_pkg::*;
(
   input logic         clk,
   input logic         rst_n,
   fir_filter_if.slave bus
);

   sample_t delay_q [NOF_COEFF];
   sample_t xnew    [NOF_COEFF];
   acc_t    products[NOF_COEFF];
   acc_t    sum;
   acc_t    fir_output_q;

   // Delay line as it will look after this edge, new sample included.
   always_comb begin
      xnew    = delay_q;
      xnew[0] = bus.input_sample;
      for (int k = 1; k < NOF_COEFF; k++) begin
         xnew[k] = delay_q[k-1];
      end
   end

   for (genvar k = 0; k < NOF_COEFF; k++) begin : g_tap
      fir_filter_mac u_mac (
         .sample  (xnew[k]),
         .weight  (bus.coeff[k]),
         .product (products[k])
      );
   end

   always_comb begin
      sum = '0;
      for (int k = 0; k < NOF_COEFF; k++) begin
         sum = sum + products[k];
      end
   end

   // rst_n is active-high; it dominates enable.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         delay_q      <= '{default: '0};
         fir_output_q <= '0;
      end else if (bus.enable) begin
         delay_q      <= xnew;
         fir_output_q <= sum;
      end
   end

   assign bus.fir_output = fir_output_q;

endmodule

// File: tb/tb_fir_filter.sv
module tb_fir_filter;
   import fir_filter_pkg::*;

   logic clk;
   logic rst_n;
   fir_filter_if bus ();

   fir_filter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run;
   int tests_failed;

   // Reference model: plain integer history (newest first) and coefficient values.
   longint cf   [NOF_COEFF];
   longint hist [NOF_COEFF];
   longint model_out;

   task automatic drive_coeff();
      for (int k = 0; k < NOF_COEFF; k++) bus.coeff[k] = sample_t'(cf[k]);
   endtask

   // Apply inputs, take one edge, sample 1 time unit later and advance the model.
   task automatic step(input logic rst, input logic en, input longint smp);
      rst_n            = rst;
      bus.enable       = en;
      bus.input_sample = sample_t'(smp);
      @(posedge clk);
      #1;
      if (rst) begin
         for (int k = 0; k < NOF_COEFF; k++) hist[k] = 0;
         model_out = 0;
      end else if (en) begin
         for (int k = NOF_COEFF - 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0]   = smp;
         model_out = 0;
         for (int k = 0; k < NOF_COEFF; k++) model_out += cf[k] * hist[k];
      end
   endtask

   task automatic check(input string tag, input longint exp);
      acc_t want;
      want = acc_t'(exp);
      tests_run++;
      assert (bus.fir_output === want) else begin
         tests_failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, $signed(bus.fir_output), exp);
      end
   endtask

   longint exp_step [8] = '{1, 3, 6, 10, 15, 21, 28, 36};
   longint smp;

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b1;
      bus.enable   = 1'b0;
      bus.input_sample = '0;
      for (int k = 0; k < NOF_COEFF; k++) begin
         cf[k]   = k + 1;
         hist[k] = 0;
      end
      model_out = 0;
      drive_coeff();
      #(RST_INITIAL_DELAY);

      // Reset held with enable toggling, then one idle cycle after release.
      for (int i = 0; i < RST_HOLD_DELAY; i++) begin
         step(1'b1, logic'(i % 2 == 0), 77);
         check("reset_hold", 0);
      end
      step(1'b0, 1'b0, 5);
      check("reset_release", 0);

      // Impulse response reproduces the coefficients.
      step(1'b0, 1'b1, 1);
      check("impulse", 1);
      for (int i = 1; i < 9; i++) begin
         step(1'b0, 1'b1, 0);
         check("impulse", (i < 8) ? longint'(i + 1) : 0);
      end

      // Step response, frozen mid-way while inputs and coefficients wiggle.
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 1);
         check("step", exp_step[i]);
      end
      for (int k = 0; k < NOF_COEFF; k++) cf[k] = 9;
      drive_coeff();
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 100);
         check("hold", 10);
      end
      for (int k = 0; k < NOF_COEFF; k++) cf[k] = k + 1;
      drive_coeff();
      for (int i = 4; i < 10; i++) begin
         step(1'b0, 1'b1, 1);
         check("step_resume", (i < 8) ? exp_step[i] : 36);
      end

      // Reset in the middle of a fresh step run, then an impulse on the cleared line.
      step(1'b1, 1'b1, 1);
      check("reset_mid", 0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1);
         check("step_again", exp_step[i]);
      end
      step(1'b1, 1'b1, 1);
      check("reset_mid", 0);
      step(1'b0, 1'b1, 1);
      check("impulse_after_reset", 1);
      for (int i = 1; i < 9; i++) begin
         step(1'b0, 1'b1, 0);
         check("impulse_after_reset", (i < 8) ? longint'(i + 1) : 0);
      end

      // Extremes: most negative times most negative on every tap.
      for (int k = 0; k < NOF_COEFF; k++) cf[k] = -32768;
      drive_coeff();
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, -32768);
         check("extreme_ramp", model_out);
      end
      check("extreme_neg_neg", 64'sd8589934592);
      for (int k = 0; k < NOF_COEFF; k++) cf[k] = 32767;
      drive_coeff();
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, -32768);
      check("extreme_pos_neg", -64'sd8589672448);

      // Randomized traffic against the model; disabled cycles carry garbage samples.
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            for (int k = 0; k < NOF_COEFF; k++) cf[k] = longint'($urandom_range(0, 65535)) - 32768;
            drive_coeff();
         end
         smp = longint'($urandom_range(0, 65535)) - 32768;
         step(logic'($urandom_range(0, 31) == 0), logic'($urandom_range(0, 3) != 0), smp);
         check("random", model_out);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
